multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle main controller for the RV32 subset datapath: lb, sb, add, and, ori, sll, bne.
- Sequences the shared ALU, register file, PC/IR and unified memory port through fetch/decode/execute/memory/writeback states.
- Generates the 4-bit ALU control code and all datapath strobes and mux selects.
- Handles a ready-based memory handshake, flags illegal instructions, and counts retired instructions.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR (and OldPC) from memory data
- pc_write  out  1  load PC
- pc_src  out  1  PC input: 0=ALU result, 1=ALUOut register
- reg_write  out  1  register file write enable
- result_src  out  1  writeback data: 0=ALUOut, 1=memory data register
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=immediate, 10=constant 4
- alu_control  out  4  0010 add, 0000 and, 0001 or, 1000 sll, 0110 not-equal compare
- illegal  out  1  sticky illegal-instruction flag
- retired  out  COUNT_W  retired-instruction count

Behaviour:
- Reset (sampled on clk edge): state<=FETCH, illegal<=0, retired<=0. While reset is high, all strobes are forced 0 (mem_read, mem_write, ir_write, pc_write, reg_write), as are all selects and alu_control=0000. Reset mid-access abandons the access; no partial writes.
- Outputs are Moore decodes of state, except that FETCH/MEM strobes are qualified by mem_ready and the BRANCH pc_write is qualified by zero. Undriven selects are 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=10, alu_control=0010, pc_src=0.
  - ir_write=pc_write=mem_ready.
  - Holds in FETCH while mem_ready=0; moves to DECODE on mem_ready.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, add (branch target into ALUOut).
  - Next state by opcode:
    - 0000011/0100011 with funct3=000 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 with funct3=110 -> EXEC_I
    - 1100011 with funct3=001 -> BRANCH
    - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, add. Goes to MEMRD for lb, MEMWR for sb.
- MEMRD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, result_src=1 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1 (held stable until mem_ready). On mem_ready goes to FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00.
  - funct7=0000000 with funct3 000->add, 111->and, 001->sll; next state ALUWB.
  - Any other funct combination -> TRAP.
- EXEC_I: alu_src_a=10, alu_src_b=01, or -> ALUWB.
- ALUWB: reg_write=1, result_src=0 -> FETCH.
- BRANCH:
  - Drives alu_src_a=10, alu_src_b=00, alu_control=0110, pc_src=1. With this code the ALU yields 0 when rs1!=rs2, so zero=1 means the branch is taken.
  - pc_write=zero; then -> FETCH.
- TRAP: illegal<=1. All strobes 0. Stays in TRAP until reset.
- retired increments by 1 on the edge leaving MEMWB, ALUWB, BRANCH (taken or not), or on the edge leaving MEMWR with mem_ready. It wraps modulo 2^COUNT_W with no saturation.
- Cycle counts with mem_ready tied 1:
  - R/I-type: 4 cycles.
  - lb: 5 cycles.
  - sb: 4 cycles.
  - bne: 3 cycles.
- mem_ready is ignored in states with no memory request.

Decomposition:
- ctrl_pkg holds:
  - state enum
  - ALU control localparams (ALU_ADD, ALU_AND, ALU_OR, ALU_SLL, ALU_NE)
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH)
  - src_a/src_b select encodings
- Sub-module alu_decoder: combinational map of (state class, funct3, funct7) -> alu_control plus a legal flag. The FSM instantiates it in EXEC_R.

Test Plan:
- Reset for 2 cycles, then release with mem_ready=1, add (opcode 0110011, f3 000, f7 0) -> states FETCH, DECODE, EXEC_R, ALUWB; alu_control 0010 in EXEC_R; reg_write=1 exactly 1 cycle; retired=1.
- lb with mem_ready low for 3 cycles in MEMRD -> mem_read and i_or_d held 1 for 4 cycles; MEMWB follows; retired+1; no reg_write before MEMWB.
- bne with zero=1, then bne with zero=0 -> first gives pc_write=1, pc_src=1 in BRANCH; second gives pc_write=0; both increment retired.
- ori (0010011, f3 110) then sll (f3 001) -> alu_control 0001 with alu_src_b=01, then 1000 with alu_src_b=00.
- Illegal cases: opcode 1101111, and R-type with f7=0100000 -> TRAP, illegal=1 sticky, all strobes 0 for 10 cycles; reset clears illegal and returns to FETCH.
- Reset asserted during MEMWR with mem_ready=0 -> mem_write=0 on the next edge; state=FETCH; retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32-subset multi-cycle controller:
// FSM states, ALU codes, opcodes, mux selects and the per-state control decode.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_R   = 2'd1,
        CLS_I   = 2'd2,
        CLS_BR  = 2'd3
    } alu_cls_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_NE  = 4'b0110;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_ORI  = 3'b110;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // fetch_en / branch_en are the unqualified FETCH and BRANCH strobes;
    // the top ANDs them with mem_ready / zero.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       fetch_en;
        logic       branch_en;
        logic       pc_src;
        logic       reg_write;
        logic       result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] alu_code);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read    = 1'b1;
                c.fetch_en    = 1'b1;
                c.alu_src_a   = SRCA_PC;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_control = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_a   = SRCA_OLDPC;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.result_src = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = alu_code;
            end
            S_EXEC_I: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = alu_code;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.branch_en   = 1'b1;
                c.pc_src      = 1'b1;
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = alu_code;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the operation class of the upcoming state plus funct fields to the
// 4-bit ALU control code, flagging R-type funct combinations we do not support.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic       legal
);

    // ALU code and legality per operation class
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (cls)
            CLS_ADD: alu_control = ALU_ADD;
            CLS_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  alu_control = ALU_ADD;
                        F3_AND:  alu_control = ALU_AND;
                        F3_SLL:  alu_control = ALU_SLL;
                        default: legal = 1'b0;
                    endcase
                end else begin
                    legal = 1'b0;
                end
            end
            CLS_I:   alu_control = ALU_OR;
            CLS_BR:  alu_control = ALU_NE;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and selects, flags illegal instructions, counts retirements.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg_write,
    output logic               result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [3:0]         alu_control,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    state_t             state_r;
    state_t             next_state_s;
    ctrl_t              ctrl_r;
    ctrl_t              ctrl_next_s;
    alu_cls_t           cls_s;
    logic [3:0]         dec_alu_s;
    logic               dec_legal_s;
    logic               legal_r;
    logic               retire_s;
    logic               illegal_r;
    logic [COUNT_W-1:0] retired_r;

    // Decoder looks at the state being entered so its result can be registered
    alu_decoder u_alu_decoder (
        .cls         (cls_s),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu_s),
        .legal       (dec_legal_s)
    );

    // Operation class of the next state
    always_comb begin
        cls_s = CLS_ADD;
        case (next_state_s)
            S_EXEC_R: cls_s = CLS_R;
            S_EXEC_I: cls_s = CLS_I;
            S_BRANCH: cls_s = CLS_BR;
            default:  cls_s = CLS_ADD;
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:  next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state_s = (funct3 == F3_BYTE) ? S_MEMADR : S_TRAP;
                    OP_R:              next_state_s = S_EXEC_R;
                    OP_IMM:            next_state_s = (funct3 == F3_ORI) ? S_EXEC_I : S_TRAP;
                    OP_BRANCH:         next_state_s = (funct3 == F3_BNE) ? S_BRANCH : S_TRAP;
                    default:           next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: next_state_s = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state_s = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR:  next_state_s = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC_R: next_state_s = legal_r ? S_ALUWB : S_TRAP;
            S_EXEC_I: next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_TRAP:   next_state_s = S_TRAP;
            default:  next_state_s = S_TRAP;
        endcase
    end

    // An instruction retires on the edge that leaves its final state
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_MEMWB, S_ALUWB, S_BRANCH: retire_s = 1'b1;
            S_MEMWR:                    retire_s = mem_ready;
            default:                    retire_s = 1'b0;
        endcase
    end

    assign ctrl_next_s = decode_ctrl(next_state_s, dec_alu_s);

    // State, registered control word, sticky illegal flag and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            ctrl_r    <= decode_ctrl(S_FETCH, ALU_ADD);
            legal_r   <= 1'b1;
            illegal_r <= 1'b0;
            retired_r <= '0;
        end else begin
            state_r   <= next_state_s;
            ctrl_r    <= ctrl_next_s;
            legal_r   <= dec_legal_s;
            illegal_r <= illegal_r | (next_state_s == S_TRAP);
            retired_r <= retired_r + COUNT_W'(retire_s);
        end
    end

    // Reset forces every strobe and select low, abandoning any access in flight
    always_comb begin
        if (reset) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            i_or_d      = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            reg_write   = 1'b0;
            result_src  = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_control = 4'b0000;
        end else begin
            mem_read    = ctrl_r.mem_read;
            mem_write   = ctrl_r.mem_write;
            i_or_d      = ctrl_r.i_or_d;
            ir_write    = ctrl_r.fetch_en & mem_ready;
            pc_write    = (ctrl_r.fetch_en & mem_ready) | (ctrl_r.branch_en & zero);
            pc_src      = ctrl_r.pc_src;
            reg_write   = ctrl_r.reg_write;
            result_src  = ctrl_r.result_src;
            alu_src_a   = ctrl_r.alu_src_a;
            alu_src_b   = ctrl_r.alu_src_b;
            alu_control = ctrl_r.alu_control;
        end
    end

    assign illegal = illegal_r;
    assign retired = retired_r;

endmodule
